// File: rtl/safe_bus_arbiter.sv
// Shares one OBI-style data master port among NHARTS cores: round-robin when independent,
// single voted copy in lockstep. Optional lockstep gather timeout: define SAFE_ARB_TIMEOUT_EN.
module safe_bus_arbiter #(
  parameter int NHARTS         = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   single_bus_i,
  input  logic [NHARTS-1:0]      master_core_i,
  input  logic [NHARTS-1:0]      core_req_i,
  input  logic [NHARTS*AW-1:0]   core_addr_i,
  input  logic [NHARTS-1:0]      core_we_i,
  input  logic [NHARTS*DW/8-1:0] core_be_i,
  input  logic [NHARTS*DW-1:0]   core_wdata_i,
  output logic [NHARTS-1:0]      core_gnt_o,
  output logic [NHARTS-1:0]      core_rvalid_o,
  output logic [DW-1:0]          core_rdata_o,
  output logic                   bus_req_o,
  output logic [AW-1:0]          bus_addr_o,
  output logic                   bus_we_o,
  output logic [DW/8-1:0]        bus_be_o,
  output logic [DW-1:0]          bus_wdata_o,
  input  logic                   bus_gnt_i,
  input  logic                   bus_rvalid_i,
  input  logic [DW-1:0]          bus_rdata_i,
  output logic [NHARTS-1:0]      mismatch_o,
  output logic                   timeout_o
);

  localparam int IW = $clog2(NHARTS);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, GATHER, ISSUE, WAIT_RESP} state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic            bcast_q, bcast_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [AW-1:0]   addr_a  [NHARTS];
  logic [BW-1:0]   be_a    [NHARTS];
  logic [DW-1:0]   wdata_a [NHARTS];

  logic [IW-1:0]   master_idx;
  logic [IW-1:0]   rr_idx;
  logic [IW-1:0]   pay_idx;
  logic [IW:0]     rr_sum;
  logic [NHARTS-1:0] diff_vec;
  logic [NHARTS-1:0] sel_oh;
  logic            all_req;
  logic            tmo_hit;

  for (genvar g = 0; g < NHARTS; g++) begin : g_unpack
    assign addr_a[g]  = core_addr_i[g*AW +: AW];
    assign be_a[g]    = core_be_i[g*BW +: BW];
    assign wdata_a[g] = core_wdata_i[g*DW +: DW];
  end

  assign all_req = &core_req_i;
  assign sel_oh  = NHARTS'(1) << sel_q;

  // Lowest set bit of the master select wins; an empty vector falls back to hart 0.
  always_comb begin
    master_idx = '0;
    for (int i = NHARTS - 1; i >= 0; i--) begin
      if (master_core_i[i]) master_idx = IW'(i);
    end
  end

  always_comb begin
    rr_idx = ptr_q;
    rr_sum = '0;
    for (int k = NHARTS - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NHARTS)) rr_sum = rr_sum - (IW+1)'(NHARTS);
      if (core_req_i[rr_sum[IW-1:0]]) rr_idx = rr_sum[IW-1:0];
    end
  end

  // Write data only matters for divergence when the master is writing.
  always_comb begin
    diff_vec = '0;
    for (int i = 0; i < NHARTS; i++) begin
      if (IW'(i) != master_idx) begin
        diff_vec[i] = (addr_a[i] != addr_a[master_idx]) ||
                      (core_we_i[i] != core_we_i[master_idx]) ||
                      (be_a[i] != be_a[master_idx]) ||
                      (core_we_i[master_idx] && (wdata_a[i] != wdata_a[master_idx]));
      end
    end
  end

`ifdef SAFE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == GATHER) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == GATHER) && !all_req &&
                   (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
  assign tmo_hit        = 1'b0;
`endif

  assign pay_idx = mode_q ? master_idx : rr_idx;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    bcast_d       = bcast_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    core_gnt_o    = '0;
    core_rvalid_o = '0;
    core_rdata_o  = '0;
    bus_req_o     = 1'b0;
    mismatch_o    = '0;
    timeout_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        mode_d = single_bus_i;
        if (!mode_q) begin
          if (|core_req_i) begin
            sel_d   = rr_idx;
            bcast_d = 1'b0;
            addr_d  = addr_a[pay_idx];
            we_d    = core_we_i[pay_idx];
            be_d    = be_a[pay_idx];
            wdata_d = wdata_a[pay_idx];
            state_d = ISSUE;
          end
        end else if (core_req_i[master_idx]) begin
          state_d = GATHER;
        end
      end

      // A timed-out gather is served to the master alone, so it is not broadcast.
      GATHER: begin
        if (all_req || tmo_hit) begin
          sel_d   = master_idx;
          bcast_d = all_req;
          addr_d  = addr_a[pay_idx];
          we_d    = core_we_i[pay_idx];
          be_d    = be_a[pay_idx];
          wdata_d = wdata_a[pay_idx];
          state_d = ISSUE;
          if (all_req) begin
            mismatch_o = diff_vec;
          end else begin
            mismatch_o = ~core_req_i;
            timeout_o  = 1'b1;
          end
        end
      end

      ISSUE: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) begin
          core_gnt_o = bcast_q ? '1 : sel_oh;
          if (!mode_q) ptr_d = (sel_q == IW'(NHARTS - 1)) ? '0 : sel_q + 1'b1;
          state_d = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        if (bus_rvalid_i) begin
          core_rvalid_o = bcast_q ? '1 : sel_oh;
          core_rdata_o  = bus_rdata_i;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus_addr_o  = addr_q;
  assign bus_we_o    = we_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      bcast_q <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bcast_q <= bcast_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_safe_bus_arbiter.sv
// Directed independent/lockstep scenarios followed by a randomized independent-mode run
// checked against a transaction-level round-robin model.
module tb_safe_bus_arbiter;

  localparam int N = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            single_bus_i;
  logic [N-1:0]    master_core_i;
  logic [N-1:0]    core_req_i;
  logic [N*32-1:0] core_addr_i;
  logic [N-1:0]    core_we_i;
  logic [N*4-1:0]  core_be_i;
  logic [N*32-1:0] core_wdata_i;
  logic [N-1:0]    core_gnt_o;
  logic [N-1:0]    core_rvalid_o;
  logic [31:0]     core_rdata_o;
  logic            bus_req_o;
  logic [31:0]     bus_addr_o;
  logic            bus_we_o;
  logic [3:0]      bus_be_o;
  logic [31:0]     bus_wdata_o;
  logic            bus_gnt_i;
  logic            bus_rvalid_i;
  logic [31:0]     bus_rdata_i;
  logic [N-1:0]    mismatch_o;
  logic            timeout_o;

  int vectors     = 0;
  int miscompares = 0;

  safe_bus_arbiter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .single_bus_i  (single_bus_i),
    .master_core_i (master_core_i),
    .core_req_i    (core_req_i),
    .core_addr_i   (core_addr_i),
    .core_we_i     (core_we_i),
    .core_be_i     (core_be_i),
    .core_wdata_i  (core_wdata_i),
    .core_gnt_o    (core_gnt_o),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .bus_req_o     (bus_req_o),
    .bus_addr_o    (bus_addr_o),
    .bus_we_o      (bus_we_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i),
    .mismatch_o    (mismatch_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic apply_stimulus(input logic [N-1:0] req, input logic gnt,
                                input logic rv, input logic [31:0] rdata);
    core_req_i   = req;
    bus_gnt_i    = gnt;
    bus_rvalid_i = rv;
    bus_rdata_i  = rdata;
    #1;
  endtask

  task automatic set_hart(input int h, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata);
    core_addr_i[h*32 +: 32]  = addr;
    core_we_i[h]             = we;
    core_be_i[h*4 +: 4]      = be;
    core_wdata_i[h*32 +: 32] = wdata;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  // Transaction-level reference state for the randomized run
  bit          pending [N];
  logic [31:0] m_addr  [N];
  logic        m_we    [N];
  logic [3:0]  m_be    [N];
  logic [31:0] m_wdata [N];
  int          busy, cur, ptr;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [N-1:0] req_v, exp_g, exp_r;
  logic        r_gnt, r_rv;
  logic [31:0] r_data;
  int          order[$];

  initial begin
    rst_ni        = 1'b0;
    single_bus_i  = 1'b0;
    master_core_i = '0;
    core_addr_i   = '0;
    core_we_i     = '0;
    core_be_i     = '0;
    core_wdata_i  = '0;
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);

    // Reset: outputs stay quiet even with requests present
    tick();
    apply_stimulus(3'b111, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check_output("rst_bus_req", bus_req_o, 0);
    check_output("rst_gnt", core_gnt_o, 0);
    check_output("rst_rvalid", core_rvalid_o, 0);
    check_output("rst_rdata", core_rdata_o, 0);
    check_output("rst_addr", bus_addr_o, 0);
    check_output("rst_mismatch", mismatch_o, 0);
    check_output("rst_timeout", timeout_o, 0);
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);
    tick();
    rst_ni = 1'b1;

    // Independent: hart1 reads 0x100
    tick();
    set_hart(1, 32'h100, 1'b0, 4'hF, 32'h0);
    apply_stimulus(3'b010, 1'b0, 1'b0, 32'h0);
    check_output("rd_idle_noreq", bus_req_o, 0);
    tick();
    apply_stimulus(3'b010, 1'b1, 1'b0, 32'h0);
    check_output("rd_bus_req", bus_req_o, 1);
    check_output("rd_bus_addr", bus_addr_o, 32'h100);
    check_output("rd_bus_we", bus_we_o, 0);
    check_output("rd_gnt", core_gnt_o, 3'b010);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);
    check_output("rd_gnt_pulse", core_gnt_o, 0);
    check_output("rd_early_rvalid", core_rvalid_o, 0);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b1, 32'hDEADBEEF);
    check_output("rd_rvalid", core_rvalid_o, 3'b010);
    check_output("rd_rdata", core_rdata_o, 32'hDEADBEEF);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'hDEADBEEF);
    check_output("rd_rvalid_pulse", core_rvalid_o, 0);
    check_output("rd_rdata_zero", core_rdata_o, 0);

    // Independent: all harts request continuously, bus always grants and responds
    do_reset();
    for (int c = 0; c < 18; c++) begin
      tick();
      apply_stimulus(3'b111, 1'b1, 1'b1, 32'h0);
      check_output("rr_onehot", ($countones(core_gnt_o) <= 1), 1);
      for (int h = 0; h < N; h++) if (core_gnt_o[h]) order.push_back(h);
    end
    check_output("rr_count", order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check_output("rr_order", (k < order.size()) ? order[k] : -1, k % 3);
    end

    // Lockstep: master hart2, identical writes
    tick();
    single_bus_i  = 1'b1;
    master_core_i = 3'b100;
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);
    tick();
    for (int h = 0; h < N; h++) set_hart(h, 32'h200, 1'b1, 4'hF, 32'hA5A5A5A5);
    apply_stimulus(3'b111, 1'b0, 1'b0, 32'h0);
    check_output("ls_idle_noreq", bus_req_o, 0);
    tick();
    apply_stimulus(3'b111, 1'b0, 1'b0, 32'h0);
    check_output("ls_mismatch", mismatch_o, 0);
    check_output("ls_gather_noreq", bus_req_o, 0);
    tick();
    apply_stimulus(3'b111, 1'b1, 1'b0, 32'h0);
    check_output("ls_bus_req", bus_req_o, 1);
    check_output("ls_addr", bus_addr_o, 32'h200);
    check_output("ls_we", bus_we_o, 1);
    check_output("ls_wdata", bus_wdata_o, 32'hA5A5A5A5);
    check_output("ls_gnt", core_gnt_o, 3'b111);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b1, 32'h0);
    check_output("ls_single_req", bus_req_o, 0);
    check_output("ls_rvalid", core_rvalid_o, 3'b111);

    // Lockstep: master hart1, hart0 diverges on write data
    tick();
    master_core_i = 3'b010;
    set_hart(0, 32'h300, 1'b1, 4'hF, 32'h1);
    set_hart(1, 32'h300, 1'b1, 4'hF, 32'h2);
    set_hart(2, 32'h300, 1'b1, 4'hF, 32'h2);
    apply_stimulus(3'b111, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(3'b111, 1'b0, 1'b0, 32'h0);
    check_output("dv_mismatch", mismatch_o, 3'b001);
    tick();
    apply_stimulus(3'b111, 1'b1, 1'b0, 32'h0);
    check_output("dv_wdata", bus_wdata_o, 32'h2);
    check_output("dv_mismatch_pulse", mismatch_o, 0);
    check_output("dv_gnt", core_gnt_o, 3'b111);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b1, 32'h55);
    check_output("dv_rvalid", core_rvalid_o, 3'b111);
    check_output("dv_rdata", core_rdata_o, 32'h55);

    // Mode rises while hart0's independent read is outstanding
    tick();
    single_bus_i = 1'b0;
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);
    tick();
    set_hart(0, 32'h400, 1'b0, 4'hF, 32'h0);
    apply_stimulus(3'b001, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(3'b001, 1'b1, 1'b0, 32'h0);
    check_output("mc_gnt", core_gnt_o, 3'b001);
    tick();
    single_bus_i = 1'b1;
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b1, 32'h1234);
    check_output("mc_rvalid", core_rvalid_o, 3'b001);
    check_output("mc_rdata", core_rdata_o, 32'h1234);
    tick();
    master_core_i = 3'b001;
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      apply_stimulus(3'b001, 1'b0, 1'b0, 32'h0);
      check_output("mc_gather_wait", bus_req_o, 0);
      check_output("mc_no_timeout", timeout_o, 0);
    end
    tick();
    apply_stimulus(3'b111, 1'b0, 1'b0, 32'h0);
    check_output("mc_mismatch", mismatch_o, 3'b110);
    tick();
    apply_stimulus(3'b111, 1'b1, 1'b0, 32'h0);
    check_output("mc_ls_gnt", core_gnt_o, 3'b111);
    check_output("mc_ls_addr", bus_addr_o, 32'h400);
    tick();
    apply_stimulus(3'b000, 1'b0, 1'b1, 32'h0);
    check_output("mc_ls_rvalid", core_rvalid_o, 3'b111);

    // Reset asserted mid-ISSUE clears outputs without waiting for a clock
    tick();
    single_bus_i = 1'b0;
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);
    tick();
    set_hart(2, 32'h500, 1'b0, 4'hF, 32'h0);
    apply_stimulus(3'b100, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(3'b100, 1'b0, 1'b0, 32'h0);
    check_output("ri_bus_req", bus_req_o, 1);
    check_output("ri_addr", bus_addr_o, 32'h500);
    bus_gnt_i = 1'b1;
    rst_ni    = 1'b0;
    #1;
    check_output("ri_rst_req", bus_req_o, 0);
    check_output("ri_rst_addr", bus_addr_o, 0);
    check_output("ri_rst_gnt", core_gnt_o, 0);
    tick();
    rst_ni = 1'b1;
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'h0);

    // Randomized independent mode against the round-robin model
    do_reset();
    busy = 0;
    cur  = 0;
    ptr  = 0;
    lat_addr = '0; lat_we = 1'b0; lat_be = '0; lat_wdata = '0;
    for (int h = 0; h < N; h++) begin
      pending[h] = 1'b0;
      m_addr[h] = '0; m_we[h] = 1'b0; m_be[h] = '0; m_wdata[h] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int h = 0; h < N; h++) begin
        if (!pending[h] && $urandom_range(0, 2) == 0) begin
          pending[h] = 1'b1;
          m_addr[h]  = $urandom;
          m_we[h]    = 1'($urandom_range(0, 1));
          m_be[h]    = 4'($urandom_range(0, 15));
          m_wdata[h] = $urandom;
        end
        set_hart(h, m_addr[h], m_we[h], m_be[h], m_wdata[h]);
        req_v[h] = pending[h];
      end
      r_gnt  = (busy == 1) && ($urandom_range(0, 1) == 1);
      r_rv   = ($urandom_range(0, 2) == 0);
      r_data = $urandom;
      apply_stimulus(req_v, r_gnt, r_rv, r_data);

      exp_g = '0;
      exp_r = '0;
      if (busy == 1 && r_gnt) exp_g[cur] = 1'b1;
      if (busy == 2 && r_rv)  exp_r[cur] = 1'b1;
      check_output("rnd_bus_req", bus_req_o, (busy == 1));
      if (busy == 1) begin
        check_output("rnd_addr", bus_addr_o, lat_addr);
        check_output("rnd_we", bus_we_o, lat_we);
        check_output("rnd_be", bus_be_o, lat_be);
        check_output("rnd_wdata", bus_wdata_o, lat_wdata);
      end
      check_output("rnd_gnt", core_gnt_o, exp_g);
      check_output("rnd_rvalid", core_rvalid_o, exp_r);
      check_output("rnd_rdata", core_rdata_o, (busy == 2 && r_rv) ? r_data : 32'h0);

      if (busy == 0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (pending[(ptr + k) % N]) begin
            cur  = (ptr + k) % N;
            busy = 1;
          end
        end
        if (busy == 1) begin
          lat_addr  = m_addr[cur];
          lat_we    = m_we[cur];
          lat_be    = m_be[cur];
          lat_wdata = m_wdata[cur];
        end
      end else if (busy == 1 && r_gnt) begin
        pending[cur] = 1'b0;
        ptr  = (cur + 1) % N;
        busy = 2;
      end else if (busy == 2 && r_rv) begin
        busy = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
